// File: rtl/fp_operand_unpack.sv
// Operand unpacker for the FP front end: classifies two IEEE-754 operands and
// registers sign, extended exponent and explicit-hidden-bit significand in one stage.
module fp_operand_unpack #(
   parameter int EXP_W     = 8,
   parameter int MAN_W     = 23,
   parameter int NORM_MODE = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   op_a,
   input  logic [EXP_W+MAN_W:0]   op_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   a_sign,
   output logic                   b_sign,
   output logic [EXP_W+1:0]       a_exp,
   output logic [EXP_W+1:0]       b_exp,
   output logic [MAN_W:0]         a_sig,
   output logic [MAN_W:0]         b_sig,
   output logic [2:0]             a_class,
   output logic [2:0]             b_class,
   output logic                   any_nan,
   output logic                   invalid
);

   localparam int XW  = EXP_W + 2;
   localparam int SW  = MAN_W + 1;
   localparam int LZW = $clog2(MAN_W) + 1;
   localparam int UW  = 3 + XW + SW;

   localparam logic [2:0] CLS_ZERO = 3'd0;
   localparam logic [2:0] CLS_SUB  = 3'd1;
   localparam logic [2:0] CLS_NORM = 3'd2;
   localparam logic [2:0] CLS_INF  = 3'd3;
   localparam logic [2:0] CLS_QNAN = 3'd4;
   localparam logic [2:0] CLS_SNAN = 3'd5;

   localparam logic [LZW-1:0] LZ_ONE  = {{(LZW-1){1'b0}}, 1'b1};
   localparam logic [XW-1:0]  EXP_ONE = {{(XW-1){1'b0}}, 1'b1};

   // Priority encoder: the highest set bit wins because it is visited last.
   function automatic logic [LZW-1:0] lzc(input logic [MAN_W-1:0] m);
      logic [LZW-1:0] lz;
      lz = '0;
      for (int i = 0; i < MAN_W; i++) begin
         if (m[i]) begin
            lz = LZW'(MAN_W - 1 - i);
         end
      end
      return lz;
   endfunction

   function automatic logic [UW-1:0] unpack(input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-1:0] m);
      logic [2:0]     cls;
      logic [XW-1:0]  x;
      logic [SW-1:0]  s;
      logic [LZW-1:0] lz;
      cls = CLS_NORM;
      x   = {2'b00, e};
      s   = {1'b1, m};
      lz  = lzc(m);
      if (e == '0) begin
         if (m == '0) begin
            cls = CLS_ZERO;
            x   = '0;
            s   = '0;
         end else begin
            cls = CLS_SUB;
            if (NORM_MODE == 1) begin
               // Shift the leading one up into the hidden-bit position; exponent goes to 1-(lz+1).
               s = SW'({1'b0, m} << (lz + LZ_ONE));
               x = '0 - XW'(lz);
            end else begin
               x = EXP_ONE;
               s = {1'b0, m};
            end
         end
      end else if (&e) begin
         if (m == '0) begin
            cls = CLS_INF;
         end else if (m[MAN_W-1]) begin
            cls = CLS_QNAN;
         end else begin
            cls = CLS_SNAN;
         end
      end else begin
         cls = CLS_NORM;
      end
      return {cls, x, s};
   endfunction

   logic [UW-1:0] ua_s, ub_s;
   logic          take_s;
   logic          nan_d, inv_d;

   logic          valid_q, valid_d;
   logic          a_sign_q, b_sign_q, nan_q, inv_q;
   logic [XW-1:0] a_exp_q, b_exp_q;
   logic [SW-1:0] a_sig_q, b_sig_q;
   logic [2:0]    a_cls_q, b_cls_q;

   assign in_ready = !valid_q | out_ready;
   assign take_s   = in_valid & in_ready;

   // Unpack both operands and derive the next valid state and flags.
   always_comb begin
      ua_s  = unpack(op_a[EXP_W+MAN_W-1:MAN_W], op_a[MAN_W-1:0]);
      ub_s  = unpack(op_b[EXP_W+MAN_W-1:MAN_W], op_b[MAN_W-1:0]);
      nan_d = (ua_s[UW-1 -: 3] == CLS_QNAN) | (ua_s[UW-1 -: 3] == CLS_SNAN) |
              (ub_s[UW-1 -: 3] == CLS_QNAN) | (ub_s[UW-1 -: 3] == CLS_SNAN);
      inv_d = (ua_s[UW-1 -: 3] == CLS_SNAN) | (ub_s[UW-1 -: 3] == CLS_SNAN);
      if (take_s) begin
         valid_d = 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Output stage register: reset clears, a transfer in reloads, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         a_sign_q <= 1'b0;
         b_sign_q <= 1'b0;
         a_exp_q  <= '0;
         b_exp_q  <= '0;
         a_sig_q  <= '0;
         b_sig_q  <= '0;
         a_cls_q  <= CLS_ZERO;
         b_cls_q  <= CLS_ZERO;
         nan_q    <= 1'b0;
         inv_q    <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (take_s) begin
            a_sign_q <= op_a[EXP_W+MAN_W];
            b_sign_q <= op_b[EXP_W+MAN_W];
            {a_cls_q, a_exp_q, a_sig_q} <= ua_s;
            {b_cls_q, b_exp_q, b_sig_q} <= ub_s;
            nan_q    <= nan_d;
            inv_q    <= inv_d;
         end
      end
   end

   assign out_valid = valid_q;
   assign a_sign    = a_sign_q;
   assign b_sign    = b_sign_q;
   assign a_exp     = a_exp_q;
   assign b_exp     = b_exp_q;
   assign a_sig     = a_sig_q;
   assign b_sig     = b_sig_q;
   assign a_class   = a_cls_q;
   assign b_class   = b_cls_q;
   assign any_nan   = nan_q;
   assign invalid   = inv_q;

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Directed bench for fp_operand_unpack: one instance per subnormal mode, shared stimulus.
module tb_fp_operand_unpack;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic [31:0] op_a, op_b;

   logic        d0_in_ready, d0_out_valid, d0_a_sign, d0_b_sign, d0_any_nan, d0_invalid;
   logic [9:0]  d0_a_exp, d0_b_exp;
   logic [23:0] d0_a_sig, d0_b_sig;
   logic [2:0]  d0_a_class, d0_b_class;

   logic        d1_in_ready, d1_out_valid, d1_a_sign, d1_b_sign, d1_any_nan, d1_invalid;
   logic [9:0]  d1_a_exp, d1_b_exp;
   logic [23:0] d1_a_sig, d1_b_sig;
   logic [2:0]  d1_a_class, d1_b_class;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fp_operand_unpack #(.EXP_W(8), .MAN_W(23), .NORM_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d0_in_ready),
      .op_a(op_a), .op_b(op_b), .out_valid(d0_out_valid), .out_ready(out_ready),
      .a_sign(d0_a_sign), .b_sign(d0_b_sign), .a_exp(d0_a_exp), .b_exp(d0_b_exp),
      .a_sig(d0_a_sig), .b_sig(d0_b_sig), .a_class(d0_a_class), .b_class(d0_b_class),
      .any_nan(d0_any_nan), .invalid(d0_invalid));

   fp_operand_unpack #(.EXP_W(8), .MAN_W(23), .NORM_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d1_in_ready),
      .op_a(op_a), .op_b(op_b), .out_valid(d1_out_valid), .out_ready(out_ready),
      .a_sign(d1_a_sign), .b_sign(d1_b_sign), .a_exp(d1_a_exp), .b_exp(d1_b_exp),
      .a_sig(d1_a_sig), .b_sig(d1_b_sig), .a_class(d1_a_class), .b_class(d1_b_class),
      .any_nan(d1_any_nan), .invalid(d1_invalid));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] b);
      op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; op_a = 32'h7FA00000; op_b = 32'h3F800000; out_ready = 1'b1;
      step(); step();
      total++; if (d0_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid0 got=%b want=0", d0_out_valid); end
      total++; if (d1_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid1 got=%b want=0", d1_out_valid); end
      total++; if ({d0_a_class, d0_a_exp, d0_a_sig, d0_b_sig} !== 61'd0) begin bad++; $display("FAIL rst_data got=%h want=0", {d0_a_class, d0_a_exp, d0_a_sig, d0_b_sig}); end
      total++; if ({d0_any_nan, d0_invalid, d0_a_sign} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {d0_any_nan, d0_invalid, d0_a_sign}); end
      rst = 1'b0; in_valid = 1'b0;
      step();
      total++; if (d0_out_valid !== 1'b0) begin bad++; $display("FAIL rst_after got=%b want=0", d0_out_valid); end
   endtask

   task automatic test_normal();
      load(32'h3F800000, 32'h00000000);
      total++; if (d0_out_valid !== 1'b1) begin bad++; $display("FAIL norm_valid got=%b want=1", d0_out_valid); end
      total++; if (d0_a_class !== 3'd2 || d0_a_exp !== 10'd127 || d0_a_sig !== 24'h800000) begin bad++; $display("FAIL norm_a got=%0d/%0d/%h want=2/127/800000", d0_a_class, d0_a_exp, d0_a_sig); end
      total++; if (d0_b_class !== 3'd0 || d0_b_exp !== 10'd0 || d0_b_sig !== 24'h0) begin bad++; $display("FAIL zero_b got=%0d/%0d/%h want=0/0/0", d0_b_class, d0_b_exp, d0_b_sig); end
      total++; if (d0_any_nan !== 1'b0) begin bad++; $display("FAIL norm_nan got=%b want=0", d0_any_nan); end
      load(32'hC0490FDB, 32'h80000000);
      total++; if (d0_a_sign !== 1'b1 || d0_a_exp !== 10'd128 || d0_a_sig !== 24'hC90FDB) begin bad++; $display("FAIL neg_norm got=%b/%0d/%h want=1/128/c90fdb", d0_a_sign, d0_a_exp, d0_a_sig); end
      total++; if (d0_b_sign !== 1'b1 || d0_b_class !== 3'd0 || d0_b_sig !== 24'h0) begin bad++; $display("FAIL neg_zero got=%b/%0d/%h want=1/0/0", d0_b_sign, d0_b_class, d0_b_sig); end
   endtask

   task automatic test_subnormal();
      load(32'h00400000, 32'h80000001);
      total++; if (d0_a_class !== 3'd1 || d0_a_exp !== 10'd1 || d0_a_sig !== 24'h400000) begin bad++; $display("FAIL sub0_a got=%0d/%h/%h want=1/001/400000", d0_a_class, d0_a_exp, d0_a_sig); end
      total++; if (d0_b_exp !== 10'd1 || d0_b_sig !== 24'h000001) begin bad++; $display("FAIL sub0_b got=%h/%h want=001/000001", d0_b_exp, d0_b_sig); end
      total++; if (d1_a_class !== 3'd1 || d1_a_exp !== 10'd0 || d1_a_sig !== 24'h800000) begin bad++; $display("FAIL sub1_a got=%0d/%h/%h want=1/000/800000", d1_a_class, d1_a_exp, d1_a_sig); end
      total++; if (d1_b_sign !== 1'b1 || d1_b_exp !== 10'h3EA || d1_b_sig !== 24'h800000) begin bad++; $display("FAIL sub1_b got=%b/%h/%h want=1/3ea/800000", d1_b_sign, d1_b_exp, d1_b_sig); end
      load(32'h007FFFFF, 32'h00000003);
      total++; if (d1_a_exp !== 10'd0 || d1_a_sig !== 24'hFFFFFE) begin bad++; $display("FAIL sub1_max got=%h/%h want=000/fffffe", d1_a_exp, d1_a_sig); end
      total++; if (d1_b_exp !== 10'h3EB || d1_b_sig !== 24'hC00000) begin bad++; $display("FAIL sub1_three got=%h/%h want=3eb/c00000", d1_b_exp, d1_b_sig); end
   endtask

   task automatic test_specials();
      load(32'h7F800000, 32'h7FA00000);
      total++; if (d0_a_class !== 3'd3 || d0_a_exp !== 10'd255 || d0_a_sig !== 24'h800000) begin bad++; $display("FAIL inf_a got=%0d/%0d/%h want=3/255/800000", d0_a_class, d0_a_exp, d0_a_sig); end
      total++; if (d0_b_class !== 3'd5 || d0_b_sig !== 24'hA00000) begin bad++; $display("FAIL snan_b got=%0d/%h want=5/a00000", d0_b_class, d0_b_sig); end
      total++; if (d0_any_nan !== 1'b1 || d0_invalid !== 1'b1) begin bad++; $display("FAIL snan_flags got=%b%b want=11", d0_any_nan, d0_invalid); end
      load(32'h7FC00000, 32'h3F800000);
      total++; if (d0_a_class !== 3'd4 || d0_a_sig !== 24'hC00000) begin bad++; $display("FAIL qnan_a got=%0d/%h want=4/c00000", d0_a_class, d0_a_sig); end
      total++; if (d0_any_nan !== 1'b1 || d0_invalid !== 1'b0) begin bad++; $display("FAIL qnan_flags got=%b%b want=10", d0_any_nan, d0_invalid); end
      load(32'h3F800000, 32'hFFC00001);
      total++; if (d0_b_class !== 3'd4 || d0_b_sign !== 1'b1 || d0_any_nan !== 1'b1 || d0_invalid !== 1'b0) begin bad++; $display("FAIL qnan_b got=%0d/%b/%b%b want=4/1/10", d0_b_class, d0_b_sign, d0_any_nan, d0_invalid); end
      load(32'h7F800001, 32'h00000000);
      total++; if (d0_a_class !== 3'd5 || d0_invalid !== 1'b1) begin bad++; $display("FAIL snan_min got=%0d/%b want=5/1", d0_a_class, d0_invalid); end
   endtask

   task automatic test_idle_hold();
      load(32'h40000000, 32'h00000000);
      step();
      total++; if (d0_out_valid !== 1'b0 || d0_a_exp !== 10'd128) begin bad++; $display("FAIL idle_hold got=%b/%0d want=0/128", d0_out_valid, d0_a_exp); end
      op_a = 32'h41000000; out_ready = 1'b0;
      step();
      total++; if (d0_out_valid !== 1'b0 || d0_a_exp !== 10'd128) begin bad++; $display("FAIL idle_ignore got=%b/%0d want=0/128", d0_out_valid, d0_a_exp); end
   endtask

   task automatic test_backpressure();
      logic [31:0] pairs [4];
      pairs[0] = 32'h3F800000; pairs[1] = 32'h40000000;
      pairs[2] = 32'h40800000; pairs[3] = 32'h41000000;
      op_a = pairs[0]; op_b = 32'h00000000; in_valid = 1'b1; out_ready = 1'b0;
      step();
      op_a = pairs[1];
      for (int c = 0; c < 3; c++) begin
         total++; if (d0_out_valid !== 1'b1 || d0_in_ready !== 1'b0 || d0_a_exp !== 10'd127) begin bad++; $display("FAIL bp_stall%0d got=%b/%b/%0d want=1/0/127", c, d0_out_valid, d0_in_ready, d0_a_exp); end
         step();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++; if (d0_out_valid !== 1'b1 || d0_a_exp !== 10'(127 + k)) begin bad++; $display("FAIL bp_order%0d got=%b/%0d want=1/%0d", k, d0_out_valid, d0_a_exp, 127 + k); end
         if (k < 3) begin
            op_a = pairs[k+1];
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
      total++; if (d0_out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", d0_out_valid); end
   endtask

   task automatic test_reset_mid();
      op_a = 32'h7FA00000; op_b = 32'hBF800000; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      total++; if (d0_out_valid !== 1'b1 || d0_invalid !== 1'b1) begin bad++; $display("FAIL mid_loaded got=%b/%b want=1/1", d0_out_valid, d0_invalid); end
      rst = 1'b1; in_valid = 1'b1; op_a = 32'h3F800000;
      step();
      rst = 1'b0; in_valid = 1'b0;
      total++; if (d0_out_valid !== 1'b0 || {d0_a_exp, d0_a_sig, d0_b_sign, d0_invalid, d0_any_nan} !== 37'd0) begin bad++; $display("FAIL mid_cleared got=%b/%h want=0/0", d0_out_valid, {d0_a_exp, d0_a_sig, d0_b_sign, d0_invalid, d0_any_nan}); end
      step();
      total++; if (d0_out_valid !== 1'b0) begin bad++; $display("FAIL mid_after got=%b want=0", d0_out_valid); end
      load(32'h3F800000, 32'h00000000);
      total++; if (d0_out_valid !== 1'b1 || d0_a_exp !== 10'd127) begin bad++; $display("FAIL mid_next got=%b/%0d want=1/127", d0_out_valid, d0_a_exp); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = 32'h0; op_b = 32'h0;
      test_reset();
      test_normal();
      test_subnormal();
      test_specials();
      test_idle_hold();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
